nns_seq_ctrl_td: RTL and testbench
==================================

# nns_seq_ctrl_td

Sequential controller for the taxicab-distance nearest-neighbour search. It streams the N database points from an external read-only memory one per cycle through a single `taxicab_distance` unit and keeps a running minimum. It returns the nearest point, its index and its distance. This is the area-minimal, time-multiplexed counterpart of the fully unrolled comparator/mux chain, and it sits between the garbled-circuit input registers and the downstream k-NN logic.

## Interface
- `W`, 15: coordinate width; each point is `{x[W-1:0], y[W-1:0]}`.
- `N`, 32: number of database points, N ≥ 1.
- `LOGN`, derived: `max(1, ceil(log2(N)))`, the address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `g_input` in 2W: query point `{x2,y2}`; latched on an accepted `start`.
- `addr` out LOGN: database read address.
- `rd_en` out 1: read strobe. The memory returns `rdata` exactly one cycle after `rd_en`.
- `rdata` in 2W: database point `{x1,y1}`.
- `busy` out 1: high from the cycle after an accepted `start` until `done` is high.
- `done` out 1: one-cycle pulse; the result is valid from this cycle on.
- `o` out 2W: nearest point.
- `o_idx` out LOGN: index of the nearest point.
- `o_dist` out W+2: distance of the nearest point.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN when the issued address is N-1.
  - DRAIN → DONE.
  - DONE → IDLE unconditionally.
- IDLE: `rd_en`=0. On `start`, latch `g_input` into `q_reg`, clear `cnt`, clear `have_min`.
- FETCH: `rd_en`=1, `addr`=`cnt`, and `cnt` increments each cycle.
- Pipeline: `rv` is `rd_en` delayed by one cycle, and `ridx` is `addr` delayed by one cycle.
- When `rv`=1:
  - `d = |x1-x2| + |y1-y2|`, computed combinationally from `rdata` and `q_reg`, zero-extended to W+2 bits.
  - If `!have_min` or `min_dist > d` (strict), load `min_val`←`rdata`, `min_idx`←`ridx`, `min_dist`←`d`, and set `have_min`.
  - On a tie the earlier (lower) index is kept.
- DRAIN: `rd_en`=0; this cycle absorbs the last returned word.
- DONE: `done`=1 and `busy`=0.
- `o`, `o_idx` and `o_dist` are driven directly from the min registers. They hold their values until the next accepted `start`.
- `start` while not in IDLE is ignored and has no side effects.
- `start` in the DONE cycle is ignored; the next cycle is IDLE.
- Reset values: state IDLE, every output 0, `have_min`=0, `q_reg`=0, `cnt`=0, `rv`=0.
- `rst` mid-search aborts immediately to these values. No partial result is retained.
- Width rules:
  - Absolute differences are W bits, unsigned, computed as max minus min.
  - The sum is W+1 bits and cannot overflow.
  - The value is held in W+2 bits for compatibility with the combinational version.

## Timing
- An accepted `start` at edge 0 gives FETCH during cycles 1..N, with `addr`=i in cycle i+1.
- Data for index i is evaluated in cycle i+2 and registered at the end of that cycle.
- DRAIN is cycle N+1. `done`=1 in cycle N+2. The result is valid in cycle N+2.
- Latency from the start edge to `done` is N+2 cycles. Back-to-back searches have a period of N+3 cycles.
- N=1: FETCH lasts one cycle, then DRAIN, then DONE in cycle 3.
- `cnt` never wraps: FETCH exits when `cnt`=N-1 is issued, including when N is a power of two.

## Structure
- The shared package `nns_pkg` holds:
  - the `log2` function;
  - state encodings IDLE/FETCH/DRAIN/DONE, 2 bits;
  - `DIST_W = W+2`.
- `taxicab_distance` is instantiated once, with parameter N=W. It is the only sub-module.
- Compare and update are inline logic, not `COMP`/`MUX` instances, so the tie rule is explicit.

## Test plan
- Basic search, W=15, N=4:
  - Query (10,10). DB = (0,0), (12,9), (30,30), (9,12).
  - Required: `done` in cycle 6, `o`=(12,9), `o_idx`=1, `o_dist`=3.
- Tie, N=4:
  - Query (5,5). DB = (7,5), (5,3), (0,0), (5,7). Indices 0, 1 and 3 all have distance 2.
  - Required: `o_idx`=0, `o`=(7,5), `o_dist`=2.
- Extreme values, W=15, N=2:
  - Query (0,0). DB = (32767,32767), (32767,32766).
  - Required: `o_idx`=1, `o_dist`=65533, with no overflow.
- Boundary, N=1:
  - Query (3,4), DB = (0,0).
  - Required: `rd_en` high for 1 cycle, `done` in cycle 3, `o_dist`=7, `o_idx`=0.
- Protocol:
  - `start` pulsed at cycle 3 during a search must be ignored: `addr` sequence unchanged and a single `done` pulse.
  - A second `start` in the cycle after `done` must give a fresh result computed with the new query.
- Reset:
  - Assert `rst` in cycle 3 of an N=32 search.
  - Required: all outputs 0 within the same cycle (asynchronous), state IDLE.
  - After release, a new search completes correctly.

Source files
------------

// File: rtl/nns_pkg.sv
// nns_pkg: shared types, widths and helpers for the nearest-neighbour search blocks
package nns_pkg;
  localparam int DEF_W = 15;
  localparam int DIST_W = DEF_W + 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/taxicab_distance.sv
// taxicab_distance: |x1-x2| + |y1-y2| of two packed {x,y} points, widened to N+2 bits
module taxicab_distance #(
  parameter int N = 15
) (
  input  logic [2*N-1:0] p1,
  input  logic [2*N-1:0] p2,
  output logic [N+1:0]   d
);
  logic [N-1:0] dx, dy;
  // absolute differences as max minus min, then a sum that cannot overflow
  always_comb begin
    dx = (p1[2*N-1:N] >= p2[2*N-1:N]) ? p1[2*N-1:N] - p2[2*N-1:N] : p2[2*N-1:N] - p1[2*N-1:N];
    dy = (p1[N-1:0] >= p2[N-1:0]) ? p1[N-1:0] - p2[N-1:0] : p2[N-1:0] - p1[N-1:0];
    d = (N+2)'(dx) + (N+2)'(dy);
  end
endmodule

// File: rtl/nns_seq_ctrl_td.sv
// nns_seq_ctrl_td: streams N database points through one distance unit and tracks the nearest
module nns_seq_ctrl_td
  import nns_pkg::*;
#(
  parameter int W = 15,
  parameter int N = 32,
  parameter int LOGN = log2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*W-1:0]    g_input,
  output logic [LOGN-1:0]   addr,
  output logic              rd_en,
  input  logic [2*W-1:0]    rdata,
  output logic              busy,
  output logic              done,
  output logic [2*W-1:0]    o,
  output logic [LOGN-1:0]   o_idx,
  output logic [W+1:0]      o_dist
);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  state_t state, nxt;
  logic [2*W-1:0] q_reg;
  logic [LOGN-1:0] cnt, ridx;
  logic rv, have_min, accept, upd;
  logic [W+1:0] d;

  taxicab_distance #(.N(W)) u_dist (.p1(rdata), .p2(q_reg), .d(d));

  // next state, read strobes and the strict-less update decision
  always_comb begin
    accept = state == IDLE && start;
    nxt = state == IDLE  ? (start ? FETCH : IDLE) :
          state == FETCH ? (cnt == LAST ? DRAIN : FETCH) :
          state == DRAIN ? DONE : IDLE;
    rd_en = state == FETCH;
    addr = rd_en ? cnt : '0;
    busy = state == FETCH || state == DRAIN;
    done = state == DONE;
    upd = rv && (!have_min || o_dist > d);
  end

  // state, query latch, saturating address counter and one-cycle read pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q_reg <= '0;
      cnt <= '0;
      rv <= 1'b0;
      ridx <= '0;
    end else begin
      state <= nxt;
      rv <= rd_en;
      ridx <= addr;
      if (accept) begin
        q_reg <= g_input;
        cnt <= '0;
      end else if (rd_en && cnt != LAST) begin
        cnt <= cnt + LOGN'(1);
      end
    end
  end

  // running minimum; ties keep the earlier index because the compare is strict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_min <= 1'b0;
      o <= '0;
      o_idx <= '0;
      o_dist <= '0;
    end else if (accept) begin
      have_min <= 1'b0;
    end else if (upd) begin
      have_min <= 1'b1;
      o <= rdata;
      o_idx <= ridx;
      o_dist <= d;
    end
  end
endmodule

// File: tb/tb_nns_seq_ctrl_td.sv
// tb_nns_seq_ctrl_td: table-driven checks of the sequential nearest-neighbour controller
module tb_nns_seq_ctrl_td;
  localparam int NI = 4;
  function automatic int nof(input int k);
    return k == 0 ? 4 : k == 1 ? 2 : k == 2 ? 1 : 32;
  endfunction
  function automatic logic [29:0] pt(input int x, input int y);
    return {15'(x), 15'(y)};
  endfunction

  typedef struct packed {
    logic [1:0]       k;
    logic [29:0]      q;
    logic [3:0][29:0] db;
    logic [29:0]      eo;
    logic [4:0]       ei;
    logic [16:0]      ed;
  } vec_t;

  function automatic vec_t mkv(input int k, input logic [29:0] q, input logic [29:0] d0, input logic [29:0] d1,
                               input logic [29:0] d2, input logic [29:0] d3, input logic [29:0] eo, input int ei, input int ed);
    vec_t v;
    v.k = 2'(k);
    v.q = q;
    v.db[0] = d0;
    v.db[1] = d1;
    v.db[2] = d2;
    v.db[3] = d3;
    v.eo = eo;
    v.ei = 5'(ei);
    v.ed = 17'(ed);
    return v;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [29:0] g_input = '0;
  logic [29:0] mem [32];
  logic start_v [NI];
  logic rd_v [NI];
  logic busy_v [NI];
  logic done_v [NI];
  logic [4:0] addr_v [NI];
  logic [4:0] idx_v [NI];
  logic [29:0] o_v [NI];
  logic [29:0] rdata_v [NI];
  logic [16:0] dist_v [NI];
  int total = 0;
  int passed = 0;
  vec_t tv [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int NN = nof(g);
    localparam int LG = nns_pkg::log2(NN);
    logic [LG-1:0] a, ix;
    nns_seq_ctrl_td #(.W(15), .N(NN)) u (
      .clk(clk), .rst(rst), .start(start_v[g]), .g_input(g_input),
      .addr(a), .rd_en(rd_v[g]), .rdata(rdata_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .o(o_v[g]), .o_idx(ix), .o_dist(dist_v[g])
    );
    assign addr_v[g] = 5'(a);
    assign idx_v[g] = 5'(ix);
    always @(posedge clk) if (rd_v[g]) rdata_v[g] <= mem[a];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run(input int k, input logic [29:0] q, input int poke, input string tag);
    int n;
    int dc, dn, rc;
    bit aok, bok;
    n = nof(k);
    dc = -1;
    dn = 0;
    rc = 0;
    aok = 1;
    bok = 1;
    g_input = q;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      start_v[k] = 1'b0;
      if (done_v[k]) begin
        dn++;
        if (dc < 0) dc = c;
      end
      if (rd_v[k]) rc++;
      if (c <= n && (rd_v[k] !== 1'b1 || addr_v[k] !== 5'(c - 1))) aok = 0;
      if (busy_v[k] !== (c <= n + 1)) bok = 0;
      if (c == poke) start_v[k] = 1'b1;
    end
    chk($sformatf("%s done_cycle", tag), dc, n + 2);
    chk($sformatf("%s done_pulses", tag), dn, 1);
    chk($sformatf("%s rd_en_cycles", tag), rc, n);
    chk($sformatf("%s addr_seq", tag), 32'(aok), 1);
    chk($sformatf("%s busy_window", tag), 32'(bok), 1);
  endtask

  task automatic chk_res(input int k, input string tag, input logic [29:0] eo, input int ei, input int ed);
    chk($sformatf("%s o", tag), 32'(o_v[k]), 32'(eo));
    chk($sformatf("%s o_idx", tag), 32'(idx_v[k]), ei);
    chk($sformatf("%s o_dist", tag), 32'(dist_v[k]), ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tv[0] = mkv(0, pt(10, 10), pt(0, 0), pt(12, 9), pt(30, 30), pt(9, 12), pt(12, 9), 1, 3);
    tv[1] = mkv(0, pt(5, 5), pt(7, 5), pt(5, 3), pt(0, 0), pt(5, 7), pt(7, 5), 0, 2);
    tv[2] = mkv(1, pt(0, 0), pt(32767, 32767), pt(32767, 32766), '0, '0, pt(32767, 32766), 1, 65533);
    tv[3] = mkv(2, pt(3, 4), pt(0, 0), '0, '0, '0, pt(0, 0), 0, 7);
    tv[4] = mkv(0, pt(100, 200), pt(0, 0), pt(50, 50), pt(300, 300), pt(100, 200), pt(100, 200), 3, 0);
    repeat (2) @(negedge clk);
    chk("reset o", 32'(o_v[0]), 0);
    chk("reset o_dist", 32'(dist_v[0]), 0);
    chk("reset busy", 32'(busy_v[0]), 0);
    chk("reset rd_en", 32'(rd_v[0]), 0);
    chk("reset done", 32'(done_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) mem[j] = tv[i].db[j];
      run(tv[i].k, tv[i].q, 0, $sformatf("v%0d", i));
      chk_res(tv[i].k, $sformatf("v%0d", i), tv[i].eo, tv[i].ei, tv[i].ed);
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) mem[j] = tv[0].db[j];
    run(0, pt(10, 10), 3, "poke");
    chk_res(0, "poke", pt(12, 9), 1, 3);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("done_start_ignored rd_en", 32'(rd_v[0]), 0);
    chk("done_start_ignored busy", 32'(busy_v[0]), 0);
    chk("done_start_ignored done", 32'(done_v[0]), 0);
    run(0, pt(30, 31), 0, "b2b");
    chk_res(0, "b2b", pt(30, 30), 2, 1);
    @(negedge clk);
    for (int i = 0; i < 32; i++) mem[i] = pt(i * 50 + 5, i * 50 + 5);
    g_input = pt(1008, 1002);
    start_v[3] = 1'b1;
    @(posedge clk);
    #1 start_v[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid busy", 32'(busy_v[3]), 1);
    chk("mid addr", 32'(addr_v[3]), 2);
    chk("mid o", 32'(o_v[3]), 32'(pt(5, 5)));
    #1 rst = 1'b1;
    #1;
    chk("abort o", 32'(o_v[3]), 0);
    chk("abort o_idx", 32'(idx_v[3]), 0);
    chk("abort o_dist", 32'(dist_v[3]), 0);
    chk("abort busy", 32'(busy_v[3]), 0);
    chk("abort rd_en", 32'(rd_v[3]), 0);
    chk("abort addr", 32'(addr_v[3]), 0);
    chk("abort done", 32'(done_v[3]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(3, pt(1008, 1002), 0, "rerun");
    chk_res(3, "rerun", pt(1005, 1005), 20, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
